usr_param_burst: RTL and testbench

USR_PARAM_BURST -- requirements
Module: usr_param_burst

---
 rtl/usr_pkg.sv | 31 +++
 rtl/usr_shift_step.sv | 28 ++
 rtl/usr_param_burst.sv | 141 ++++++++++++++
 tb/tb_usr_param_burst.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the usr_param_burst shift-register engine: operation
// codes, controller states and a mode classification helper.
package usr_pkg;

   typedef enum logic [2:0] {
      MODE_LOAD  = 3'd0,
      MODE_SHR   = 3'd1,
      MODE_SHL   = 3'd2,
      MODE_ROR   = 3'd3,
      MODE_ROL   = 3'd4,
      MODE_ASR   = 3'd5,
      MODE_CLEAR = 3'd6,
      MODE_NOP   = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   function automatic logic is_shift_mode(input mode_e m);
      logic r;
      case (m)
         MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR: r = 1'b1;
         default:                                          r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the register for each shift/rotate mode;
// non-shift modes pass the value through unchanged.
module usr_shift_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  mode_e              mode_i,
   input  logic [WIDTH-1:0]   value_i,
   input  logic               fill_left_i,
   input  logic               fill_right_i,
   output logic [WIDTH-1:0]   value_o
);

   // One-bit move selected by the latched operation code.
   always_comb begin
      value_o = value_i;
      case (mode_i)
         MODE_SHR: value_o = {fill_left_i, value_i[WIDTH-1:1]};
         MODE_SHL: value_o = {value_i[WIDTH-2:0], fill_right_i};
         MODE_ROR: value_o = {value_i[0], value_i[WIDTH-1:1]};
         MODE_ROL: value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
         MODE_ASR: value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
         default:  value_o = value_i;
      endcase
   end

endmodule

// File: rtl/usr_param_burst.sv
// Command-driven shift register that executes multi-step shifts one bit per
// falling clock edge. Define USR_PARAM_BURST_ABORT_EN to add Abort_In.
module usr_param_burst
   import usr_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               Clk_In,
   input  logic               Reset_In,
`ifdef USR_PARAM_BURST_ABORT_EN
   input  logic               Abort_In,
`endif
   input  logic               Cmd_Valid_In,
   output logic               Cmd_Ready_Out,
   input  logic [2:0]         Cmd_Mode_In,
   input  logic [CNT_W-1:0]   Cmd_Count_In,
   input  logic               Serial_Data_Left_In,
   input  logic               Serial_Data_Right_In,
   input  logic [WIDTH-1:0]   Parallel_Data_In,
   output logic [WIDTH-1:0]   Parallel_Data_Out,
   output logic               Serial_Data_Right_Out,
   output logic               Serial_Data_Left_Out,
   output logic               Busy_Out,
   output logic               Done_Out
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e              state_q;
   mode_e               mode_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WIDTH-1:0]    data_q;
   logic                ready_q;
   logic                busy_q;
   logic                done_q;
   logic [WIDTH-1:0]    step_d;
   mode_e               cmd_mode_s;

   assign cmd_mode_s = mode_e'(Cmd_Mode_In);

   usr_shift_step #(
      .WIDTH        (WIDTH)
   ) u_step (
      .mode_i       (mode_q),
      .value_i      (data_q),
      .fill_left_i  (Serial_Data_Left_In),
      .fill_right_i (Serial_Data_Right_In),
      .value_o      (step_d)
   );

   // Controller, data register and status flags, all on the falling edge.
   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_NOP;
         cnt_q   <= '0;
         data_q  <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Cmd_Valid_In) begin
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  case (cmd_mode_s)
                     MODE_LOAD: begin
                        data_q  <= Parallel_Data_In;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end
                     MODE_CLEAR: begin
                        data_q  <= '0;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end
                     MODE_NOP: begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end
                     default: begin
                        // Shift modes only capture the command; stepping starts next edge.
                        mode_q <= cmd_mode_s;
                        cnt_q  <= Cmd_Count_In;
                        if (Cmd_Count_In != '0) begin
                           state_q <= ST_SHIFT;
                           done_q  <= 1'b0;
                        end else begin
                           state_q <= ST_DONE;
                           done_q  <= 1'b1;
                        end
                     end
                  endcase
               end else begin
                  done_q <= 1'b0;
               end
            end
            ST_SHIFT: begin
`ifdef USR_PARAM_BURST_ABORT_EN
               if (Abort_In) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else
`endif
               begin
                  data_q <= step_d;
                  cnt_q  <= cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     done_q  <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Cmd_Ready_Out         = ready_q;
   assign Busy_Out              = busy_q;
   assign Done_Out              = done_q;
   assign Parallel_Data_Out     = data_q;
   assign Serial_Data_Right_Out = data_q[0];
   assign Serial_Data_Left_Out  = data_q[WIDTH-1];

endmodule

// File: tb/tb_usr_param_burst.sv
// Scoreboard bench for usr_param_burst (WIDTH=16) with an arithmetic reference model.
module tb_usr_param_burst;

   localparam int W  = 16;
   localparam int CW = 5;

   logic          Clk_In = 1'b0;
   logic          Reset_In;
   logic          Abort_In;
   logic          Cmd_Valid_In;
   logic          Cmd_Ready_Out;
   logic [2:0]    Cmd_Mode_In;
   logic [CW-1:0] Cmd_Count_In;
   logic          Serial_Data_Left_In;
   logic          Serial_Data_Right_In;
   logic [W-1:0]  Parallel_Data_In;
   logic [W-1:0]  Parallel_Data_Out;
   logic          Serial_Data_Right_Out;
   logic          Serial_Data_Left_Out;
   logic          Busy_Out;
   logic          Done_Out;

   usr_param_burst #(.WIDTH(W), .CNT_W(CW)) dut (
      .Clk_In                (Clk_In),
      .Reset_In              (Reset_In),
`ifdef USR_PARAM_BURST_ABORT_EN
      .Abort_In              (Abort_In),
`endif
      .Cmd_Valid_In          (Cmd_Valid_In),
      .Cmd_Ready_Out         (Cmd_Ready_Out),
      .Cmd_Mode_In           (Cmd_Mode_In),
      .Cmd_Count_In          (Cmd_Count_In),
      .Serial_Data_Left_In   (Serial_Data_Left_In),
      .Serial_Data_Right_In  (Serial_Data_Right_In),
      .Parallel_Data_In      (Parallel_Data_In),
      .Parallel_Data_Out     (Parallel_Data_Out),
      .Serial_Data_Right_Out (Serial_Data_Right_Out),
      .Serial_Data_Left_Out  (Serial_Data_Left_Out),
      .Busy_Out              (Busy_Out),
      .Done_Out              (Done_Out)
   );

   always #5 Clk_In = ~Clk_In;

   typedef struct {
      int unsigned val;
      int unsigned lat;
      int unsigned acc;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned edge_cnt = 0;
   int unsigned model_reg = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always @(negedge Clk_In) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Result of one whole command, from the operation's arithmetic meaning.
   function automatic int unsigned model(input int m, input int unsigned v, input int n,
                                         input bit fl, input bit fr, input int unsigned d);
      int unsigned ones = 32'h0000_FFFF;
      int k = n % W;
      int sv;
      case (m)
         0: return d & ones;
         1: if (n >= W) return fl ? ones : 32'd0;
            else return (v >> n) | (fl ? ((ones << (W - n)) & ones) : 32'd0);
         2: if (n >= W) return fr ? ones : 32'd0;
            else return ((v << n) & ones) | (fr ? ((32'd1 << n) - 32'd1) : 32'd0);
         3: return ((v >> k) | (v << (W - k))) & ones;
         4: return ((v << k) | (v >> (W - k))) & ones;
         5: begin
            sv = (v & 32'h8000) != 0 ? int'(v | 32'hFFFF_0000) : int'(v);
            return int'(sv >>> n) & ones;
         end
         6: return 32'd0;
         default: return v;
      endcase
   endfunction

   task automatic issue(input int m, input int n, input int unsigned d, input bit fl,
                        input bit fr, input bit push, output int unsigned acc);
      int unsigned e;
      int unsigned lat;
      @(posedge Clk_In); #1;
      chk("cmd_ready", Cmd_Ready_Out, 1);
      Cmd_Valid_In         = 1'b1;
      Cmd_Mode_In          = m[2:0];
      Cmd_Count_In         = n[CW-1:0];
      Parallel_Data_In     = d[W-1:0];
      Serial_Data_Left_In  = fl;
      Serial_Data_Right_In = fr;
      acc = edge_cnt + 1;
      e   = model(m, model_reg, n, fl, fr, d);
      lat = (m >= 1 && m <= 5 && n > 0) ? n + 1 : 1;
      if (push) sb_q.push_back('{e, lat, acc});
      model_reg = e;
      @(negedge Clk_In); #1;
      Cmd_Valid_In = 1'b0;
   endtask

   // Waits for IDLE, optionally firing commands that must be ignored.
   task automatic wait_idle(input bit pulse);
      bit done = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge Clk_In); #1;
         if (!Busy_Out) begin
            done = 1'b1;
            break;
         end
         if (pulse) begin
            Cmd_Valid_In     = 1'($urandom_range(0, 1));
            Cmd_Mode_In      = 3'($urandom_range(0, 7));
            Cmd_Count_In     = CW'($urandom_range(0, 31));
            Parallel_Data_In = W'($urandom);
         end
      end
      Cmd_Valid_In = 1'b0;
      if (!done) chk("idle_timeout", 1, 0);
   endtask

   // Monitor: every Done pulse retires exactly one expected command.
   always @(posedge Clk_In) begin
      exp_t e;
      if (!Reset_In && Done_Out === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk("result", Parallel_Data_Out, e.val);
            chk("latency", edge_cnt - e.acc + 1, e.lat);
            chk("serial_outs", {Serial_Data_Left_Out, Serial_Data_Right_Out},
                {e.val[15], e.val[0]});
         end
      end
   end

   initial begin
      int unsigned acc;
      int unsigned shr_seq[4] = '{32'h8078, 32'hC03C, 32'hE01E, 32'hF00F};
      int m, n;
      Reset_In = 1'b1; Abort_In = 1'b0; Cmd_Valid_In = 1'b0; Cmd_Mode_In = 3'd0;
      Cmd_Count_In = '0; Serial_Data_Left_In = 1'b0; Serial_Data_Right_In = 1'b0;
      Parallel_Data_In = '0;
      repeat (2) @(posedge Clk_In);
      #1;
      chk("rst_data", Parallel_Data_Out, 0);
      chk("rst_busy", Busy_Out, 0);
      chk("rst_ready", Cmd_Ready_Out, 1);
      chk("rst_done", Done_Out, 0);
      Reset_In = 1'b0;

      issue(0, 0, 32'hA5C3, 0, 0, 1, acc);
      @(posedge Clk_In); #1;
      chk("load_value", Parallel_Data_Out, 32'hA5C3);
      chk("load_done", Done_Out, 1);
      wait_idle(0);

      issue(0, 0, 32'h00F0, 0, 0, 1, acc);
      wait_idle(0);
      issue(1, 4, 0, 1, 0, 1, acc);
      @(posedge Clk_In);
      chk("shr_accept_hold", Parallel_Data_Out, 32'h00F0);
      for (int i = 0; i < 4; i++) begin
         @(posedge Clk_In);
         chk("shr_step", Parallel_Data_Out, shr_seq[i]);
      end
      wait_idle(0);

      issue(0, 0, 32'h8001, 0, 0, 1, acc); wait_idle(1);
      issue(4, 20, 0, 0, 0, 1, acc);       wait_idle(1);
      chk("rol20", Parallel_Data_Out, 32'h0018);
      issue(0, 0, 32'h8010, 0, 0, 1, acc); wait_idle(1);
      issue(5, 3, 0, 0, 1, 1, acc);        wait_idle(1);
      chk("asr3", Parallel_Data_Out, 32'hF002);
      issue(2, 0, 0, 0, 1, 1, acc);        wait_idle(1);
      chk("shl0", Parallel_Data_Out, 32'hF002);

`ifdef USR_PARAM_BURST_ABORT_EN
      issue(0, 0, 32'hFFFF, 0, 0, 1, acc); wait_idle(0);
      issue(2, 10, 0, 0, 0, 0, acc);
      sb_q.push_back('{32'hFFFC, 4, acc});
      model_reg = 32'hFFFC;
      @(negedge Clk_In);
      @(negedge Clk_In); #1;
      Abort_In = 1'b1;
      @(negedge Clk_In); #1;
      Abort_In = 1'b0;
      wait_idle(0);
      chk("abort_value", Parallel_Data_Out, 32'hFFFC);
`endif

      for (int t = 0; t < 40; t++) begin
         m = $urandom_range(0, 7);
         n = $urandom_range(0, 31);
         issue(m, n, $urandom & 32'hFFFF, 1'($urandom), 1'($urandom), 1, acc);
         wait_idle(1);
      end

      issue(0, 0, 32'h1234, 0, 0, 1, acc); wait_idle(0);
      issue(1, 8, 0, 1, 0, 1, acc);
      repeat (3) @(posedge Clk_In);
      #1;
      Reset_In = 1'b1;
      #1;
      chk("midrst_data", Parallel_Data_Out, 0);
      chk("midrst_busy", Busy_Out, 0);
      chk("midrst_ready", Cmd_Ready_Out, 1);
      chk("midrst_done", Done_Out, 0);
      sb_q.delete();
      model_reg = 0;
      Cmd_Valid_In = 1'b1; Cmd_Mode_In = 3'd0; Parallel_Data_In = 16'hFFFF;
      @(posedge Clk_In); #1;
      Cmd_Valid_In = 1'b0;
      Reset_In = 1'b0;
      @(posedge Clk_In); #1;
      chk("rst_no_accept_data", Parallel_Data_Out, 0);
      chk("rst_no_accept_busy", Busy_Out, 0);

      repeat (3) @(posedge Clk_In);
      chk("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
